// File: rtl/mips_pkg.sv
// Shared types for the MEM-stage store buffer: entry layout and word/byte-enable widths.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    // Addresses are byte addresses but entries match on whole words.
    localparam logic [WORD_W-1:0] WORD_MASK = {{(WORD_W-2){1'b1}}, 2'b00};

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic [BE_W-1:0]   be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store, memory-write and load-lookup signals of the store buffer.
interface store_buffer_if #(
    parameter int unsigned AW = mips_pkg::WORD_W,
    parameter int unsigned DW = mips_pkg::WORD_W
) ();

    logic                      st_valid;
    logic                      st_ready;
    logic [AW-1:0]             st_addr;
    logic [DW-1:0]             st_data;
    logic [mips_pkg::BE_W-1:0] st_be;

    logic                      mem_we;
    logic [AW-1:0]             mem_addr;
    logic [DW-1:0]             mem_data;
    logic [mips_pkg::BE_W-1:0] mem_be;
    logic                      mem_busy;

    logic [AW-1:0]             ld_addr;
    logic                      ld_hit;
    logic [DW-1:0]             ld_data;
    logic                      ld_stall;

    modport master (
        output st_valid, st_addr, st_data, st_be, mem_busy, ld_addr,
        input  st_ready, mem_we, mem_addr, mem_data, mem_be, ld_hit, ld_data, ld_stall
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_be, mem_busy, ld_addr,
        output st_ready, mem_we, mem_addr, mem_data, mem_be, ld_hit, ld_data, ld_stall
    );

endinterface

// File: rtl/sb_match.sv
// Load-address lookup across buffered stores; reports the youngest valid word match.
module sb_match
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] i_entries,
    input  logic [DEPTH-1:0]      i_valid,
    input  logic [PW-1:0]         i_wr_ptr,
    input  logic [WORD_W-1:0]     i_ld_addr,
    output logic                  o_match,
    output logic                  o_full_be,
    output logic [WORD_W-1:0]     o_data
);

    logic [DEPTH-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_hit[i] = i_valid[i] &&
                       ((i_entries[i].addr & WORD_MASK) == (i_ld_addr & WORD_MASK));
        end
    end

    // Scan from wr_ptr (oldest slot) towards wr_ptr-1 (youngest); the last hit wins.
    always_comb begin
        o_match   = 1'b0;
        o_full_be = 1'b0;
        o_data    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_hit[i_wr_ptr + PW'(k)]) begin
                o_match   = 1'b1;
                o_full_be = (i_entries[i_wr_ptr + PW'(k)].be == '1);
                o_data    = i_entries[i_wr_ptr + PW'(k)].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM-stage register and data memory, with load lookup.
// Define STORE_FWD_EN to forward full-word matches to loads instead of stalling them.
module store_buffer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          ref_clk,
    input  logic          reset_n,
    store_buffer_if.slave bus,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    sb_entry_t [DEPTH-1:0] r_entries;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_enq;
    logic                  w_deq;
    sb_entry_t             w_head;
    logic [PW-1:0]         w_off [DEPTH];
    logic [DEPTH-1:0]      w_valid;
    logic                  w_match;
    logic                  w_full_be;
    logic [WORD_W-1:0]     w_fwd_data;

    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

    // Ready ignores a same-cycle drain so a full buffer never reuses the departing slot.
    assign bus.st_ready = !full;
    assign w_enq        = bus.st_valid && !full;
    assign w_deq        = !empty && !bus.mem_busy;

    assign w_head       = r_entries[r_rd_ptr];
    assign bus.mem_we   = !empty;
    assign bus.mem_addr = empty ? '0 : w_head.addr;
    assign bus.mem_data = empty ? '0 : w_head.data;
    assign bus.mem_be   = empty ? '0 : w_head.be;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (w_enq) r_entries[r_wr_ptr] <= {bus.st_addr, bus.st_data, bus.st_be};
    end

    // Slot i is live when its distance from the head is below the occupancy.
    always_comb begin
        w_off   = '{default: '0};
        w_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off[i]   = PW'(i) - r_rd_ptr;
            w_valid[i] = ({1'b0, w_off[i]} < r_count);
        end
    end

    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .i_entries (r_entries),
        .i_valid   (w_valid),
        .i_wr_ptr  (r_wr_ptr),
        .i_ld_addr (bus.ld_addr),
        .o_match   (w_match),
        .o_full_be (w_full_be),
        .o_data    (w_fwd_data)
    );

`ifdef STORE_FWD_EN
    assign bus.ld_hit   = w_match && w_full_be;
    assign bus.ld_data  = (w_match && w_full_be) ? w_fwd_data : '0;
    assign bus.ld_stall = w_match && !w_full_be;
`else
    logic w_unused;
    assign w_unused     = w_full_be ^ (^w_fwd_data);
    assign bus.ld_hit   = 1'b0;
    assign bus.ld_data  = '0;
    assign bus.ld_stall = w_match;
`endif

endmodule
